// File: rtl/memoria_resp.sv
// Purpose : word-array memory responder; clears itself after reset, then serves read/write requests.
// Latency : read data and ReadValid appear READ_LATENCY cycles after the accepting edge (fully pipelined).
// Backpressure: none toward the initiator; Busy=1 during the post-reset clear, and requests are dropped then.
//
// Ports:
//   Clock        clock, rising-edge active
//   Reset        asynchronous, active-low reset
//   Address      word address shared by read and write requests
//   ReadEnable   read request, sampled on each rising edge
//   WriteEnable  write request, sampled on each rising edge
//   DataIN       write data
//   DataOut      read data; holds the last returned word between results
//   ReadValid    one-cycle strobe per returned read
//   Busy         high while the array is being cleared
module memoria_resp #(
    parameter int DATA_WIDTH   = 16,
    parameter int ADDR_WIDTH   = 5,
    parameter int READ_LATENCY = 1      // legal range 1..4
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic [ADDR_WIDTH-1:0] Address,
    input  logic                  ReadEnable,
    input  logic                  WriteEnable,
    input  logic [DATA_WIDTH-1:0] DataIN,
    output logic [DATA_WIDTH-1:0] DataOut,
    output logic                  ReadValid,
    output logic                  Busy
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic {
        INIT,
        READY
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   clr_cnt_q, clr_cnt_d;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   mem_waddr;
    logic [DATA_WIDTH-1:0]   mem_wdat;
    logic                    rd_acc;

    // Read pipeline: stage 0 is loaded on the accepting edge, the last stage drives the outputs.
    logic [READ_LATENCY-1:0] vld_q;
    logic [DATA_WIDTH-1:0]   dat_q [READ_LATENCY];

    // ------------------------------------------------------------------
    // Control FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q   <= INIT;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Control FSM: next state, array write port and read acceptance
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        mem_we    = 1'b0;
        mem_waddr = Address;
        mem_wdat  = DataIN;
        rd_acc    = 1'b0;

        case (state_q)
            INIT: begin
                // The clear owns the write port; initiator requests are dropped.
                mem_we    = 1'b1;
                mem_waddr = clr_cnt_q;
                mem_wdat  = '0;
                clr_cnt_d = clr_cnt_q + ADDR_WIDTH'(1);
                // All-ones counter means word DEPTH-1 is cleared on this edge.
                if (&clr_cnt_q) begin
                    state_d = READY;
                end
            end
            READY: begin
                mem_we = WriteEnable;
                rd_acc = ReadEnable;
            end
            default: begin
                state_d = INIT;
            end
        endcase
    end

    assign Busy = (state_q == INIT);

    // ------------------------------------------------------------------
    // Word array (contents are not reset; INIT clears them)
    // ------------------------------------------------------------------
    always_ff @(posedge Clock) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdat;
        end
    end

    // ------------------------------------------------------------------
    // Read pipeline. Sampling the array with the pre-edge contents gives
    // read-first behaviour when a write hits the same word on the same edge.
    // Data stages only load on a valid so the last stage holds between results.
    // ------------------------------------------------------------------
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            vld_q <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                dat_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= rd_acc;
            if (rd_acc) begin
                dat_q[0] <= mem[Address];
            end
            for (int i = 1; i < READ_LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
                if (vld_q[i-1]) begin
                    dat_q[i] <= dat_q[i-1];
                end
            end
        end
    end

    assign ReadValid = vld_q[READ_LATENCY-1];
    assign DataOut   = dat_q[READ_LATENCY-1];

endmodule

// File: tb/tb_memoria_resp.sv
// Directed bench for memoria_resp: two instances (read latency 1 and 3)
// share clock, reset and request inputs; each scenario task checks inline.
module tb_memoria_resp;

    logic        Clock;
    logic        Reset;
    logic [4:0]  Address;
    logic        ReadEnable;
    logic        WriteEnable;
    logic [15:0] DataIN;

    logic [15:0] dout1, dout3;
    logic        rv1, rv3;
    logic        busy1, busy3;

    int checks   = 0;
    int failures = 0;

    memoria_resp #(.DATA_WIDTH(16), .ADDR_WIDTH(5), .READ_LATENCY(1)) dut1 (
        .Clock(Clock), .Reset(Reset), .Address(Address),
        .ReadEnable(ReadEnable), .WriteEnable(WriteEnable), .DataIN(DataIN),
        .DataOut(dout1), .ReadValid(rv1), .Busy(busy1)
    );

    memoria_resp #(.DATA_WIDTH(16), .ADDR_WIDTH(5), .READ_LATENCY(3)) dut3 (
        .Clock(Clock), .Reset(Reset), .Address(Address),
        .ReadEnable(ReadEnable), .WriteEnable(WriteEnable), .DataIN(DataIN),
        .DataOut(dout3), .ReadValid(rv3), .Busy(busy3)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Advance one rising edge; outputs are then sampled 1 time unit after it.
    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic idle(input int n);
        ReadEnable  = 1'b0;
        WriteEnable = 1'b0;
        repeat (n) step();
    endtask

    task automatic write_word(input logic [4:0] a, input logic [15:0] d);
        ReadEnable  = 1'b0;
        WriteEnable = 1'b1;
        Address     = a;
        DataIN      = d;
        step();
        WriteEnable = 1'b0;
    endtask

    // Count cycles until Busy drops, bounded so a stuck DUT cannot hang the run.
    task automatic wait_init(input string name);
        int n;
        n = 0;
        while (busy1 && n < 100) begin
            step();
            n++;
        end
        checks++; if (n !== 32) begin failures++; $display("FAIL %s_busy_cycles got=%0d exp=32", name, n); end
        checks++; if (busy3 !== 1'b0) begin failures++; $display("FAIL %s_busy3 got=%b exp=0", name, busy3); end
    endtask

    task automatic test_reset();
        Reset = 1'b0; Address = '0; ReadEnable = 1'b0; WriteEnable = 1'b0; DataIN = '0;
        #2;
        checks++; if (busy1 !== 1'b1) begin failures++; $display("FAIL reset_busy got=%b exp=1", busy1); end
        checks++; if (rv1 !== 1'b0 || rv3 !== 1'b0) begin failures++; $display("FAIL reset_rv got=%b%b exp=00", rv1, rv3); end
        checks++; if (dout1 !== 16'h0 || dout3 !== 16'h0) begin failures++; $display("FAIL reset_dout got=%h/%h exp=0000", dout1, dout3); end
        step(); step();
        Reset = 1'b1;
        checks++; if (busy1 !== 1'b1) begin failures++; $display("FAIL release_busy got=%b exp=1", busy1); end
        wait_init("init");
    endtask

    task automatic test_clear();
        for (int i = 0; i < 32; i++) begin
            ReadEnable = 1'b1;
            Address    = 5'(i);
            step();
            checks++;
            if (rv1 !== 1'b1 || dout1 !== 16'h0000) begin
                failures++; $display("FAIL clear_read a=%0d got rv=%b d=%h exp rv=1 d=0000", i, rv1, dout1);
            end
        end
        idle(1);
        checks++; if (rv1 !== 1'b0) begin failures++; $display("FAIL clear_rv_drop got=%b exp=0", rv1); end
        idle(3);
    endtask

    task automatic test_write_read();
        write_word(5'd5, 16'hBEEF);
        checks++; if (rv1 !== 1'b0) begin failures++; $display("FAIL wr_no_rv got=%b exp=0", rv1); end
        ReadEnable = 1'b1; Address = 5'd5;
        step();
        checks++; if (rv1 !== 1'b1) begin failures++; $display("FAIL rd5_rv got=%b exp=1", rv1); end
        checks++; if (dout1 !== 16'hBEEF) begin failures++; $display("FAIL rd5_data got=%h exp=beef", dout1); end
        idle(1);
        checks++; if (rv1 !== 1'b0) begin failures++; $display("FAIL rd5_one_cycle got=%b exp=0", rv1); end
        checks++; if (dout1 !== 16'hBEEF) begin failures++; $display("FAIL rd5_hold got=%h exp=beef", dout1); end
        idle(3);
    endtask

    task automatic test_back_to_back();
        logic [15:0] vals [4];
        vals[0] = 16'h0011; vals[1] = 16'h0022; vals[2] = 16'h0033; vals[3] = 16'h0044;
        for (int i = 0; i < 4; i++) write_word(5'(i), vals[i]);
        idle(3);
        for (int k = 0; k < 8; k++) begin
            ReadEnable = (k < 4);
            Address    = 5'(k % 4);
            step();
            // Latency 3: result of the read issued at step k shows after step k+2.
            if (k >= 2 && k <= 5) begin
                checks++;
                if (rv3 !== 1'b1 || dout3 !== vals[k-2]) begin
                    failures++; $display("FAIL b2b_lat3 k=%0d got rv=%b d=%h exp rv=1 d=%h", k, rv3, dout3, vals[k-2]);
                end
            end else begin
                checks++;
                if (rv3 !== 1'b0) begin failures++; $display("FAIL b2b_lat3_idle k=%0d got rv=%b exp=0", k, rv3); end
            end
            if (k < 4) begin
                checks++;
                if (rv1 !== 1'b1 || dout1 !== vals[k]) begin
                    failures++; $display("FAIL b2b_lat1 k=%0d got rv=%b d=%h exp rv=1 d=%h", k, rv1, dout1, vals[k]);
                end
            end
        end
        checks++; if (dout3 !== 16'h0044) begin failures++; $display("FAIL b2b_hold got=%h exp=0044", dout3); end
        idle(1);
    endtask

    task automatic test_read_first();
        write_word(5'd7, 16'h1234);
        ReadEnable = 1'b1; WriteEnable = 1'b1; Address = 5'd7; DataIN = 16'hABCD;
        step();
        checks++;
        if (rv1 !== 1'b1 || dout1 !== 16'h1234) begin
            failures++; $display("FAIL rf_old got rv=%b d=%h exp rv=1 d=1234", rv1, dout1);
        end
        WriteEnable = 1'b0;
        step();
        checks++;
        if (rv1 !== 1'b1 || dout1 !== 16'hABCD) begin
            failures++; $display("FAIL rf_new got rv=%b d=%h exp rv=1 d=abcd", rv1, dout1);
        end
        idle(1);
        checks++; if (rv3 !== 1'b1 || dout3 !== 16'h1234) begin failures++; $display("FAIL rf_old_lat3 got rv=%b d=%h exp rv=1 d=1234", rv3, dout3); end
        idle(1);
        checks++; if (rv3 !== 1'b1 || dout3 !== 16'hABCD) begin failures++; $display("FAIL rf_new_lat3 got rv=%b d=%h exp rv=1 d=abcd", rv3, dout3); end
        idle(2);
    endtask

    // mem[2] holds 16'h0033 from the back-to-back test; a re-INIT must clear it
    // and the write attempted during INIT must be dropped.
    task automatic test_busy_ignored();
        int n;
        bit seen_rv;
        Reset = 1'b0;
        step();
        Reset = 1'b1;
        ReadEnable = 1'b1; WriteEnable = 1'b1; Address = 5'd2; DataIN = 16'hFFFF;
        n = 0; seen_rv = 1'b0;
        while (busy1 && n < 100) begin
            step();
            n++;
            if (rv1 || rv3) seen_rv = 1'b1;
        end
        ReadEnable = 1'b0; WriteEnable = 1'b0;
        checks++; if (n !== 32) begin failures++; $display("FAIL busy_req_cycles got=%0d exp=32", n); end
        checks++; if (seen_rv !== 1'b0) begin failures++; $display("FAIL busy_req_rv got=%b exp=0", seen_rv); end
        // First cycle with Busy=0: served normally.
        ReadEnable = 1'b1; Address = 5'd2;
        step();
        checks++;
        if (rv1 !== 1'b1 || dout1 !== 16'h0000) begin
            failures++; $display("FAIL busy_mem2 got rv=%b d=%h exp rv=1 d=0000", rv1, dout1);
        end
        idle(4);
    endtask

    task automatic test_reset_inflight();
        bit seen_rv;
        write_word(5'd9, 16'h5555);
        ReadEnable = 1'b1; Address = 5'd9;
        step();
        checks++; if (dout1 !== 16'h5555) begin failures++; $display("FAIL inflight_pre got=%h exp=5555", dout1); end
        step();
        ReadEnable = 1'b0;
        // Two reads are now inside the latency-3 pipeline.
        Reset = 1'b0;
        #1;
        checks++; if (rv3 !== 1'b0 || dout3 !== 16'h0) begin failures++; $display("FAIL inflight_async got rv=%b d=%h exp rv=0 d=0000", rv3, dout3); end
        seen_rv = 1'b0;
        repeat (4) begin
            step();
            if (rv3) seen_rv = 1'b1;
        end
        checks++; if (seen_rv !== 1'b0) begin failures++; $display("FAIL inflight_rv got=%b exp=0", seen_rv); end
        Reset = 1'b1;
        wait_init("reinit");
        checks++; if (dout1 !== 16'h0 || dout3 !== 16'h0) begin failures++; $display("FAIL reinit_dout got=%h/%h exp=0000", dout1, dout3); end
        ReadEnable = 1'b1; Address = 5'd9;
        step();
        ReadEnable = 1'b0;
        checks++; if (rv1 !== 1'b1 || dout1 !== 16'h0000) begin failures++; $display("FAIL reinit_mem9 got rv=%b d=%h exp rv=1 d=0000", rv1, dout1); end
        step(); step();
        checks++; if (rv3 !== 1'b1 || dout3 !== 16'h0000) begin failures++; $display("FAIL reinit_mem9_lat3 got rv=%b d=%h exp rv=1 d=0000", rv3, dout3); end
    endtask

    initial begin
        test_reset();
        test_clear();
        test_write_read();
        test_back_to_back();
        test_read_first();
        test_busy_ignored();
        test_reset_inflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
